// File: rtl/morse_tx.sv
// Morse-style symbol transmitter: shifts a table or custom pattern out LSB-first,
// one symbol per divided tick, followed by a forced-low inter-letter gap.
module morse_tx #(
    parameter int PAT_W     = 14,
    parameter int TICK_DIV  = 25000000,
    parameter int GAP_TICKS = 3,
    localparam int LW       = $clog2(PAT_W + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [2:0]       sel,
    input  logic             custom_en,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [LW-1:0]    len_in,
    input  logic             start,
    input  logic             repeat_en,
    input  logic             abort,
    output logic             sym,
    output logic             busy,
    output logic             done,
    output logic [1:0]       fsm_state
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam logic [CW-1:0] TICK_RELOAD = CW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_RELOAD  = GW'(GAP_TICKS);
    localparam logic [LW-1:0] LEN_MAX     = LW'(PAT_W);

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

    // Handshake: start is level-sampled and only accepted in IDLE; busy covers
    // SEND and GAP; done pulses for one cycle when each letter's gap completes.
    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [PAT_W-1:0] shift, lat_pat, ld_pat;
    logic [LW-1:0]    remaining, lat_len, ld_len;
    logic [GW-1:0]    gap_cnt;
    logic             tick, last_sym, last_gap;

    assign tick     = (cnt == '0);
    assign last_sym = tick && (remaining == LW'(1));
    assign last_gap = tick && (gap_cnt == GW'(1));

    always_comb begin
        ld_pat = '0;
        ld_len = '0;
        if (custom_en) begin
            ld_pat = pat_in;
            ld_len = (len_in > LEN_MAX) ? LEN_MAX : len_in;
        end else begin
            case (sel)
                3'd0: begin ld_pat = PAT_W'(16'h0015); ld_len = LW'(5);  end
                3'd1: begin ld_pat = PAT_W'(16'h0007); ld_len = LW'(3);  end
                3'd2: begin ld_pat = PAT_W'(16'h0075); ld_len = LW'(7);  end
                3'd3: begin ld_pat = PAT_W'(16'h01D5); ld_len = LW'(9);  end
                3'd4: begin ld_pat = PAT_W'(16'h01DD); ld_len = LW'(9);  end
                3'd5: begin ld_pat = PAT_W'(16'h0757); ld_len = LW'(11); end
                3'd6: begin ld_pat = PAT_W'(16'h1DD7); ld_len = LW'(13); end
                3'd7: begin ld_pat = PAT_W'(16'h0577); ld_len = LW'(11); end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = (ld_len != '0) ? SEND : GAP;
            SEND: if (last_sym) state_next = GAP;
            GAP:  if (last_gap) begin
                      if (repeat_en) state_next = (lat_len != '0) ? SEND : GAP;
                      else           state_next = IDLE;
                  end
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    always_comb begin
        busy      = (state != IDLE);
        fsm_state = state;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n || abort) begin
            sym       <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            shift     <= '0;
            remaining <= '0;
            gap_cnt   <= '0;
            lat_pat   <= '0;
            lat_len   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    lat_pat   <= ld_pat;
                    lat_len   <= ld_len;
                    shift     <= ld_pat;
                    remaining <= ld_len;
                    gap_cnt   <= GAP_RELOAD;
                    cnt       <= TICK_RELOAD;
                    sym       <= (ld_len != '0) && ld_pat[0];
                end
                SEND: if (tick) begin
                    cnt <= TICK_RELOAD;
                    if (remaining == LW'(1)) begin
                        sym       <= 1'b0;
                        remaining <= '0;
                        gap_cnt   <= GAP_RELOAD;
                    end else begin
                        shift     <= shift >> 1;
                        sym       <= shift[1];
                        remaining <= remaining - LW'(1);
                    end
                end else begin
                    cnt <= cnt - CW'(1);
                end
                GAP: if (tick) begin
                    cnt     <= TICK_RELOAD;
                    gap_cnt <= gap_cnt - GW'(1);
                    if (gap_cnt == GW'(1)) begin
                        done <= 1'b1;
                        if (repeat_en) begin
                            // Repeat replays the letter captured at start, not live inputs.
                            shift     <= lat_pat;
                            remaining <= lat_len;
                            gap_cnt   <= GAP_RELOAD;
                            sym       <= (lat_len != '0) && lat_pat[0];
                        end else begin
                            cnt <= '0;
                        end
                    end
                end else begin
                    cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/morse_tx.md
Name: morse_tx

Overview:
Parametrised Morse-style symbol transmitter. It loads one of eight built-in letter patterns, or a caller-supplied custom pattern, and shifts it out LSB-first on a single output at one symbol per tick. Tick rate comes from an internal programmable divider. The block adds a start/busy/done handshake, an inter-letter gap, repeat mode and abort. It drives an LED or buzzer directly and sits behind switch/key inputs.

Parameters:
PAT_W, 14, pattern register width in bits (≥13, so every table entry fits)
TICK_DIV, 25000000, clock cycles per symbol tick (≥2); 0.5 s at 50 MHz
GAP_TICKS, 3, ticks of forced-low output after each letter (≥1)

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
sel  in  3  letter table index, sampled at accepted start
custom_en  in  1  at accepted start: 1 = use pat_in/len_in instead of table
pat_in  in  PAT_W  custom pattern, LSB sent first
len_in  in  clog2(PAT_W+1)  custom length in bits; 0 means no symbols, gap only
start  in  1  request a transmission; level-sampled, accepted only in IDLE
repeat_en  in  1  if 1 at end of gap, retransmit latched letter
abort  in  1  synchronous stop, highest priority after reset
sym  out  1  registered symbol output
busy  out  1  1 in SEND or GAP
done  out  1  one-cycle pulse at end of each letter's gap

Behaviour:
- Reset (async, reset_n=0): state IDLE; sym=0, busy=0, done=0; shift register, bit count and tick counter = 0.
- Table (pattern/length), indexed by sel:
  - 0: 0x0015/5
  - 1: 0x0007/3
  - 2: 0x0075/7
  - 3: 0x01D5/9
  - 4: 0x01DD/9
  - 5: 0x0757/11
  - 6: 0x1DD7/13
  - 7: 0x0577/11
  - Entries are zero-extended to PAT_W.
- States: IDLE, SEND, GAP.
- Tick: counter loads TICK_DIV-1 on entry to SEND or GAP and decrements each cycle. Tick occurs when counter==0, and the counter then reloads TICK_DIV-1. Every symbol and gap tick therefore lasts exactly TICK_DIV cycles.
- IDLE, start=1 at edge N:
  - Latch pattern and length from table or custom, plus custom_en and sel.
  - busy=1 from N.
  - If length>0: state SEND, sym=pattern[0], remaining=length.
  - If length==0: state GAP, sym=0.
- SEND tick:
  - If remaining==1: go to GAP, sym=0.
  - Otherwise shift right by 1, sym=next bit, remaining-1.
- GAP: sym=0 for GAP_TICKS ticks. On the final tick, done=1 for that single cycle. Then:
  - If repeat_en=1: reload the latched letter and enter SEND (or GAP if length 0) on the same edge; busy stays 1.
  - Otherwise: state IDLE, busy=0.
- Frame timing: start edge to done edge = (L+GAP_TICKS)*TICK_DIV cycles.
- start while busy: ignored, no queuing. sel, pat_in and len_in changes during busy: no effect until the next accepted start or repeat reload. Repeat reuses the values latched at start, not live inputs.
- start held high continuously: a new letter starts on the cycle after busy falls (IDLE for exactly 1 cycle).
- abort=1 in any state: next edge → IDLE, sym=0, busy=0, done=0, counters cleared. abort overrides start in the same cycle.
- len_in > PAT_W: clamp to PAT_W.
- reset_n asserted mid-letter: immediate clear, no done pulse.

Test Plan:
- TICK_DIV=4, GAP_TICKS=3, sel=1, start 1 cycle → sym=1 for 12 cycles, then 0 for 12; done pulse exactly 24 cycles after start edge; busy low the next cycle.
- sel=0 (0x15, len 5), TICK_DIV=4 → sym sequence per 4-cycle slot 1,0,1,0,1; then 12 low cycles; done at cycle 32.
- custom_en=1, pat_in=0x0003, len_in=2, repeat_en=1 → pattern 1,1,gap repeats; done every 20 cycles; changing pat_in mid-run does not alter output; dropping repeat_en → IDLE after next done.
- start pulsed during SEND of sel=6 → ignored; frame completes at 64 cycles; len_in=0 custom → no high symbols, done after 12 cycles.
- abort at cycle 10 of sel=5 frame → sym=0, busy=0 next cycle, no done; following start transmits normally from bit 0.
- reset_n low mid-GAP, asynchronously → sym/busy/done 0 immediately; after release, start with sel=2 gives a full 40-cycle frame.
